// File: rtl/fu_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fu_mul_pipe
// Brief    : Pipelined integer multiply functional unit (MUL/MULH/MULHSU/MULHU)
//            with LATENCY stages and valid/ready backpressure. Empty stages
//            are filled even when the output stage is stalled. The destination
//            tag and ROB index travel with each op through the pipeline.
//            Optional macro FU_MUL_EARLY_WAKEUP_EN adds early_valid and
//            early_dest_prn, which announce next cycle's output-stage op.
// Revision : 1.0 - initial release
// ============================================================================
module fu_mul_pipe #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,    // 1..8
    parameter int PRN_W   = 7,
    parameter int ROB_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_op_a,
    input  logic [XLEN-1:0]  in_op_b,
    input  logic [1:0]       in_func,
    input  logic [PRN_W-1:0] in_dest_prn,
    input  logic [ROB_W-1:0] in_rob_entry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [PRN_W-1:0] out_dest_prn,
    output logic [ROB_W-1:0] out_rob_entry
`ifdef FU_MUL_EARLY_WAKEUP_EN
    ,
    output logic             early_valid,
    output logic [PRN_W-1:0] early_dest_prn
`endif
);

    localparam int C_LAST = LATENCY - 1;

    localparam logic [1:0] C_FUNC_MUL    = 2'b00;
    localparam logic [1:0] C_FUNC_MULH   = 2'b01;
    localparam logic [1:0] C_FUNC_MULHSU = 2'b10;

    // Per-stage state; index C_LAST is the output stage.
    logic [LATENCY-1:0] r_valid;
    logic [XLEN-1:0]    r_result [LATENCY];
    logic [PRN_W-1:0]   r_prn    [LATENCY];
    logic [ROB_W-1:0]   r_rob    [LATENCY];

    logic [LATENCY-1:0] w_free;
    logic               w_accept;
    logic               w_a_signed;
    logic               w_b_signed;
    logic [2*XLEN-1:0]  w_a_wide;
    logic [2*XLEN-1:0]  w_b_wide;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_slice;

    // Stage k can take a new occupant when any stage from k to the output is
    // empty (that hole absorbs the shift) or the output is being consumed.
    // Written without a stage-to-stage chain to keep the logic flat.
    always_comb begin
        w_free = '0;
        for (int k = 0; k < LATENCY; k++) begin
            w_free[k] = out_ready;
            for (int j = k; j < LATENCY; j++) begin
                if (!r_valid[j]) begin
                    w_free[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = w_free[0];
    assign w_accept = in_valid && w_free[0] && !flush;

    // Operand extension and product slice selection. Sign-extending to
    // 2*XLEN and keeping the low 2*XLEN bits of the product is bit-exact
    // with the (XLEN+1)-bit signed multiply.
    always_comb begin
        w_a_signed = (in_func == C_FUNC_MULH) || (in_func == C_FUNC_MULHSU);
        w_b_signed = (in_func == C_FUNC_MULH);
        w_a_wide   = {{XLEN{w_a_signed & in_op_a[XLEN-1]}}, in_op_a};
        w_b_wide   = {{XLEN{w_b_signed & in_op_b[XLEN-1]}}, in_op_b};
        w_prod     = w_a_wide * w_b_wide;
        w_slice    = (in_func == C_FUNC_MUL) ? w_prod[XLEN-1:0]
                                             : w_prod[2*XLEN-1:XLEN];
    end

    // Stage registers: reset beats flush, flush beats accept/advance.
    // Data is only loaded when a live op moves in, so a stalled output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_result[k] <= '0;
                r_prn[k]    <= '0;
                r_rob[k]    <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (w_free[0]) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_result[0] <= w_slice;
                    r_prn[0]    <= in_dest_prn;
                    r_rob[0]    <= in_rob_entry;
                end
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (w_free[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_result[k] <= r_result[k-1];
                        r_prn[k]    <= r_prn[k-1];
                        r_rob[k]    <= r_rob[k-1];
                    end
                end
            end
        end
    end

    assign out_valid     = r_valid[C_LAST];
    assign out_result    = r_result[C_LAST];
    assign out_dest_prn  = r_prn[C_LAST];
    assign out_rob_entry = r_rob[C_LAST];

`ifdef FU_MUL_EARLY_WAKEUP_EN
    logic             w_early_valid;
    logic [PRN_W-1:0] w_early_prn;

    // Identify the op that will sit in the output stage next cycle.
    if (LATENCY == 1) begin : g_early_l1
        always_comb begin
            w_early_valid = w_accept;
            w_early_prn   = in_dest_prn;
        end
    end else begin : g_early_ln
        always_comb begin
            w_early_valid = 1'b0;
            w_early_prn   = '0;
            if (w_free[C_LAST]) begin
                w_early_valid = r_valid[C_LAST-1];
                w_early_prn   = r_prn[C_LAST-1];
            end else begin
                w_early_valid = r_valid[C_LAST];
                w_early_prn   = r_prn[C_LAST];
            end
        end
    end

    assign early_valid    = w_early_valid && !flush && !rst;
    assign early_dest_prn = early_valid ? w_early_prn : '0;
`endif

`ifndef SYNTHESIS
    // out_valid may only rise if an op was accepted or already in flight.
    a_rise_needs_op: assert property (@(posedge clk) disable iff (rst)
        $rose(out_valid) |-> $past(w_accept || (|r_valid)));

    // A stalled output keeps its payload until it is taken.
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_result) && $stable(out_dest_prn)
             && $stable(out_rob_entry)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_mul_pipe
// Brief    : Scoreboard bench for fu_mul_pipe. Accepted ops are pushed with a
//            model result; outputs are popped and compared in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_mul_pipe;

    localparam int XLEN  = 32;
    localparam int LAT   = 2;
    localparam int PRN_W = 7;
    localparam int ROB_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_op_a;
    logic [XLEN-1:0]  in_op_b;
    logic [1:0]       in_func;
    logic [PRN_W-1:0] in_dest_prn;
    logic [ROB_W-1:0] in_rob_entry;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [PRN_W-1:0] out_dest_prn;
    logic [ROB_W-1:0] out_rob_entry;
`ifdef FU_MUL_EARLY_WAKEUP_EN
    logic             early_valid;
    logic [PRN_W-1:0] early_dest_prn;
`endif

    fu_mul_pipe #(
        .XLEN    (XLEN),
        .LATENCY (LAT),
        .PRN_W   (PRN_W),
        .ROB_W   (ROB_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op_a       (in_op_a),
        .in_op_b       (in_op_b),
        .in_func       (in_func),
        .in_dest_prn   (in_dest_prn),
        .in_rob_entry  (in_rob_entry),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_dest_prn  (out_dest_prn),
        .out_rob_entry (out_rob_entry)
`ifdef FU_MUL_EARLY_WAKEUP_EN
        ,
        .early_valid   (early_valid),
        .early_dest_prn(early_dest_prn)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic [PRN_W-1:0] prn;
        logic [ROB_W-1:0] rob;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference multiply using native signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        logic [31:0]     r;
        r = '0;
        case (f)
            2'd0: begin pu = {32'b0, a} * {32'b0, b}; r = pu[31:0]; end
            2'd1: begin p = longint'(int'(a)) * longint'(int'(b)); r = p[63:32]; end
            2'd2: begin p = longint'(int'(a)) * longint'({32'b0, b}); r = p[63:32]; end
            default: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
        endcase
        return r;
    endfunction

    // Monitor: samples on the falling edge, mid-cycle.
    logic             prev_stall = 1'b0;
    logic [31:0]      prev_res;
    logic [PRN_W-1:0] prev_prn;
    logic [ROB_W-1:0] prev_rob;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_val("hold_valid", out_valid, 1);
                    check_val("hold_result", out_result, prev_res);
                    check_val("hold_prn", out_dest_prn, prev_prn);
                    check_val("hold_rob", out_rob_entry, prev_rob);
                end
                if (flush) begin
                    sb.delete();
                end else begin
                    if (out_valid && out_ready) begin
                        check_val("flushed_tag", out_dest_prn[6], 0);
                        check_val("sb_has_entry", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check_val("out_result", out_result, e.res);
                            check_val("out_prn", out_dest_prn, e.prn);
                            check_val("out_rob", out_rob_entry, e.rob);
                        end
                    end
                    if (in_valid && in_ready) begin
                        e.res = model(in_func, in_op_a, in_op_b);
                        e.prn = in_dest_prn;
                        e.rob = in_rob_entry;
                        sb.push_back(e);
                    end
                end
                prev_stall = out_valid && !out_ready && !flush;
                prev_res   = out_result;
                prev_prn   = out_dest_prn;
                prev_rob   = out_rob_entry;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [PRN_W-1:0] prn, input logic [ROB_W-1:0] rob);
        in_valid     = 1'b1;
        in_func      = f;
        in_op_a      = a;
        in_op_b      = b;
        in_dest_prn  = prn;
        in_rob_entry = rob;
    endtask

    task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [PRN_W-1:0] prn, input logic [ROB_W-1:0] rob);
        int k;
        drive(f, a, b, prn, rob);
        #1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (k >= 200) check_val("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            step();
            k++;
        end
        if (sb.size() != 0) check_val("drain_timeout", sb.size(), 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          acc;
        logic        ev_prev;
        logic [PRN_W-1:0] ep_prev;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op_a = '0; in_op_b = '0; in_func = '0; in_dest_prn = '0; in_rob_entry = '0;
        ev_prev = 1'b0; ep_prev = '0;
        repeat (3) step();

        // Reset state
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_result", out_result, 0);
        check_val("rst_out_prn", out_dest_prn, 0);
        check_val("rst_out_rob", out_rob_entry, 0);
        rst = 1'b0;
        step();

        // Single MUL 7x6, latency measurement
        drive(2'd0, 32'd7, 32'd6, 7'd5, 5'd3);
        #1;
        check_val("t1_in_ready", in_ready, 1);
`ifdef FU_MUL_EARLY_WAKEUP_EN
        ev_prev = early_valid;
        ep_prev = early_dest_prn;
`endif
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            check_val("t1_in_ready_wait", in_ready, 1);
`ifdef FU_MUL_EARLY_WAKEUP_EN
            ev_prev = early_valid;
            ep_prev = early_dest_prn;
`endif
            step();
            n++;
        end
        check_val("t1_latency", n, LAT);
        check_val("t1_result", out_result, 42);
        check_val("t1_prn", out_dest_prn, 5);
        check_val("t1_rob", out_rob_entry, 3);
        check_val("t1_in_ready_out", in_ready, 1);
`ifdef FU_MUL_EARLY_WAKEUP_EN
        check_val("t1_early_valid", ev_prev, 1);
        check_val("t1_early_prn", ep_prev, 5);
        check_val("t1_early_drop", early_valid, 0);
`endif
        drain();

        // Back-to-back high-half variants of all-ones operands
        send(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd10, 5'd1);
        send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd11, 5'd2);
        send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd12, 5'd3);
        send(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd13, 5'd4);
        drain();

        // Stall with continuous issue: pipeline fills, then drains in order
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            drive(2'(i), 32'h8000_0000 + 32'(i * 977), 32'h7FFF_FFF0 - 32'(i * 31),
                  7'(20 + i), 5'(i));
            #1;
            if (in_ready) acc++;
            step();
        end
        check_val("t3_accepts", acc, LAT);
        drive(2'd2, 32'hFFFF_FFF0, 32'd99, 7'd30, 5'd9);
        #1;
        check_val("t3_full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check_val("t3_release_in_ready", in_ready, 1);
        step();
        drain();

        // Flush with every stage occupied and an input presented
        for (int i = 0; i < LAT; i++) begin
            send(2'd0, 32'(i + 2), 32'd3, 7'(64 + i), 5'(i));
        end
        drive(2'd0, 32'd9, 32'd9, 7'd127, 5'd31);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("t4_out_valid_after_flush", out_valid, 0);
        check_val("t4_in_ready_after_flush", in_ready, 1);
        for (int i = 0; i < LAT + 1; i++) begin
            step();
            check_val("t4_no_ghost", out_valid, 0);
        end
        send(2'd0, 32'd123, 32'd4, 7'd17, 5'd9);
        drain();

        // Reset mid-stream while stalled
        out_ready = 1'b0;
        drive(2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 7'd40, 5'd4);
        step();
        drive(2'd1, 32'h8765_4321, 32'hCAFE_F00D, 7'd41, 5'd5);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check_val("t5_out_valid", out_valid, 0);
        check_val("t5_in_ready", in_ready, 1);
        check_val("t5_out_result", out_result, 0);
        check_val("t5_out_prn", out_dest_prn, 0);
`ifdef FU_MUL_EARLY_WAKEUP_EN
        check_val("t5_early_valid", early_valid, 0);
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        send(2'd0, 32'd5, 32'd5, 7'd6, 5'd6);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 120; i++) begin
            in_valid     = ($urandom % 2) == 0;
            in_func      = 2'($urandom % 4);
            in_op_a      = $urandom;
            in_op_b      = $urandom;
            in_dest_prn  = 7'($urandom % 64);
            in_rob_entry = 5'($urandom % 32);
            out_ready    = ($urandom % 4) != 0;
            step();
        end
        drain();

        check_val("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
